// File: rtl/alu_result_tx.sv
// Serial reporter: snapshots the ALU result and flags on a send request and
// shifts them out as two UART 8N1 bytes (result, then {00000, C, V, Z}).
module alu_result_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_send,
  input  logic [N-1:0] i_result,
  input  logic         i_zero,
  input  logic         i_overflow,
  input  logic         i_carry,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            byte_idx_q, byte_idx_d;
  logic [15:0]     shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      res_ext_s;
  logic            baud_end_s;

  // Zero-extend the ALU result to a full byte for any N in 1..8.
  always_comb begin
    res_ext_s         = 8'd0;
    res_ext_s[N-1:0]  = i_result;
  end

  assign baud_end_s = (baud_q == BAUD_LAST);

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + CW'(1);
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (i_send) begin
          state_d    = S_START;
          byte_idx_d = 1'b0;
          bit_d      = 3'd0;
          shreg_d    = {5'b00000, i_carry, i_overflow, i_zero, res_ext_s};
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          // A 16-bit right shift leaves byte 1 in the low byte after byte 0 is sent.
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[15:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (byte_idx_q == 1'b0) begin
            state_d    = S_START;
            byte_idx_d = 1'b1;
            bit_d      = 3'd0;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_idx_q <= 1'b0;
      shreg_q    <= 16'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: records the TX line per cycle after an
// accept and decodes it by sampling mid-bit.
module tb_alu_result_tx;

  localparam int C = 4;

  logic       clk;
  logic       reset;
  logic       i_send;
  logic [7:0] i_result;
  logic       i_zero;
  logic       i_overflow;
  logic       i_carry;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic tx_a   [0:127];
  logic busy_a [0:127];
  logic done_a [0:127];

  alu_result_tx #(.N(8), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_send     (i_send),
    .i_result   (i_result),
    .i_zero     (i_zero),
    .i_overflow (i_overflow),
    .i_carry    (i_carry),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs and a one-cycle send; returns #1 after the accept edge.
  task automatic drive_send(input logic [7:0] res, input logic z, input logic v, input logic c);
    i_result   = res;
    i_zero     = z;
    i_overflow = v;
    i_carry    = c;
    i_send     = 1'b1;
    @(posedge clk); #1;
  endtask

  // Record outputs for cycles 1..ncyc after the accept edge; optional send poke / reset pulse.
  task automatic capture(input int ncyc, input int poke_c, input logic [7:0] poke_val, input int rst_c);
    for (int cy = 1; cy <= ncyc; cy++) begin
      tx_a[cy]   = o_tx;
      busy_a[cy] = o_busy;
      done_a[cy] = o_done;
      i_send     = (cy == poke_c);
      if (cy == poke_c) i_result = poke_val;
      reset      = (cy == rst_c);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [7:0] dec(input int bi);
    logic [7:0] v;
    v = 8'h00;
    for (int b = 0; b < 8; b++) v[b] = tx_a[(bi*10 + 1 + b)*C + C/2 + 1];
    return v;
  endfunction

  function automatic logic frame_ok(input int bi);
    return (tx_a[(bi*10)*C + C/2 + 1] == 1'b0) && (tx_a[(bi*10 + 9)*C + C/2 + 1] == 1'b1);
  endfunction

  function automatic int busy_cnt(input int n);
    int k;
    k = 0;
    for (int i = 1; i <= n; i++) if (busy_a[i]) k++;
    return k;
  endfunction

  function automatic int done_cnt(input int n);
    int k;
    k = 0;
    for (int i = 1; i <= n; i++) if (done_a[i]) k++;
    return k;
  endfunction

  function automatic int done_at(input int n);
    for (int i = 1; i <= n; i++) if (done_a[i]) return i;
    return -1;
  endfunction

  task automatic idle(input int n);
    i_send = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_send = 1'b0; i_result = 8'h00;
    i_zero = 1'b0; i_overflow = 1'b0; i_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_cnt++; if (o_tx !== 1'b1) $display("FAIL reset_tx cyc%0d: got %b want 1", i, o_tx); else pass_cnt++;
      check_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy cyc%0d: got %b want 0", i, o_busy); else pass_cnt++;
      check_cnt++; if (o_done !== 1'b0) $display("FAIL reset_done cyc%0d: got %b want 0", i, o_done); else pass_cnt++;
      @(posedge clk); #1;
    end
    // Reset and send together: request must be dropped.
    reset = 1'b1; i_send = 1'b1; i_result = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0; i_send = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_send_busy cyc%0d: got %b want 0", i, o_busy); else pass_cnt++;
      check_cnt++; if (o_tx !== 1'b1) $display("FAIL rst_send_tx cyc%0d: got %b want 1", i, o_tx); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_normal();
    drive_send(8'h3B, 1'b0, 1'b0, 1'b0);
    capture(84, -1, 8'h00, -1);
    check_cnt++; if (frame_ok(0) !== 1'b1) $display("FAIL norm_frame0: got %b want 1", frame_ok(0)); else pass_cnt++;
    check_cnt++; if (dec(0) !== 8'h3B) $display("FAIL norm_byte0: got %h want 3b", dec(0)); else pass_cnt++;
    check_cnt++; if (frame_ok(1) !== 1'b1) $display("FAIL norm_frame1: got %b want 1", frame_ok(1)); else pass_cnt++;
    check_cnt++; if (dec(1) !== 8'h00) $display("FAIL norm_byte1: got %h want 00", dec(1)); else pass_cnt++;
    check_cnt++; if (busy_cnt(84) != 80) $display("FAIL norm_busy_len: got %0d want 80", busy_cnt(84)); else pass_cnt++;
    check_cnt++; if (busy_a[1] !== 1'b1 || busy_a[80] !== 1'b1 || busy_a[81] !== 1'b0)
      $display("FAIL norm_busy_edges: got %b%b%b want 110", busy_a[1], busy_a[80], busy_a[81]); else pass_cnt++;
    check_cnt++; if (done_cnt(84) != 1) $display("FAIL norm_done_cnt: got %0d want 1", done_cnt(84)); else pass_cnt++;
    check_cnt++; if (done_at(84) != 81) $display("FAIL norm_done_at: got %0d want 81", done_at(84)); else pass_cnt++;
    check_cnt++; if (tx_a[1] !== 1'b0 || tx_a[4] !== 1'b0 || tx_a[5] !== 1'b1)
      $display("FAIL norm_start_bit: got %b%b%b want 001", tx_a[1], tx_a[4], tx_a[5]); else pass_cnt++;
    check_cnt++; if (tx_a[81] !== 1'b1) $display("FAIL norm_tx_done: got %b want 1", tx_a[81]); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_flags();
    drive_send(8'h00, 1'b1, 1'b0, 1'b1);
    capture(84, -1, 8'h00, -1);
    check_cnt++; if (dec(0) !== 8'h00) $display("FAIL flagA_byte0: got %h want 00", dec(0)); else pass_cnt++;
    check_cnt++; if (dec(1) !== 8'h05 || frame_ok(1) !== 1'b1) $display("FAIL flagA_byte1: got %h want 05", dec(1)); else pass_cnt++;
    check_cnt++; if (done_at(84) != 81) $display("FAIL flagA_done_at: got %0d want 81", done_at(84)); else pass_cnt++;
    idle(1);
    drive_send(8'h80, 1'b0, 1'b1, 1'b0);
    capture(84, -1, 8'h00, -1);
    check_cnt++; if (dec(0) !== 8'h80 || frame_ok(0) !== 1'b1) $display("FAIL flagB_byte0: got %h want 80", dec(0)); else pass_cnt++;
    check_cnt++; if (dec(1) !== 8'h02) $display("FAIL flagB_byte1: got %h want 02", dec(1)); else pass_cnt++;
    check_cnt++; if (done_cnt(84) != 1) $display("FAIL flagB_done_cnt: got %0d want 1", done_cnt(84)); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_snapshot();
    drive_send(8'hAA, 1'b0, 1'b0, 1'b0);
    capture(90, 10, 8'h55, -1);
    check_cnt++; if (dec(0) !== 8'hAA) $display("FAIL snap_byte0: got %h want aa", dec(0)); else pass_cnt++;
    check_cnt++; if (dec(1) !== 8'h00) $display("FAIL snap_byte1: got %h want 00", dec(1)); else pass_cnt++;
    check_cnt++; if (done_cnt(90) != 1) $display("FAIL snap_done_cnt: got %0d want 1", done_cnt(90)); else pass_cnt++;
    check_cnt++; if (busy_cnt(90) != 80) $display("FAIL snap_busy_len: got %0d want 80", busy_cnt(90)); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    drive_send(8'h3C, 1'b0, 1'b0, 1'b0);
    capture(81, 81, 8'h11, -1);
    check_cnt++; if (dec(0) !== 8'h3C) $display("FAIL b2b_first_byte0: got %h want 3c", dec(0)); else pass_cnt++;
    check_cnt++; if (done_a[81] !== 1'b1 || tx_a[81] !== 1'b1 || busy_a[81] !== 1'b0)
      $display("FAIL b2b_done_cycle: got done=%b tx=%b busy=%b want 1 1 0", done_a[81], tx_a[81], busy_a[81]); else pass_cnt++;
    capture(84, -1, 8'h00, -1);
    check_cnt++; if (tx_a[1] !== 1'b0 || busy_a[1] !== 1'b1)
      $display("FAIL b2b_no_gap: got tx=%b busy=%b want 0 1", tx_a[1], busy_a[1]); else pass_cnt++;
    check_cnt++; if (dec(0) !== 8'h11) $display("FAIL b2b_byte0: got %h want 11", dec(0)); else pass_cnt++;
    check_cnt++; if (dec(1) !== 8'h00) $display("FAIL b2b_byte1: got %h want 00", dec(1)); else pass_cnt++;
    check_cnt++; if (done_at(84) != 81) $display("FAIL b2b_done_at: got %0d want 81", done_at(84)); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive_send(8'h77, 1'b0, 1'b0, 1'b0);
    capture(90, -1, 8'h00, 15);
    check_cnt++; if (busy_a[15] !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy_a[15]); else pass_cnt++;
    check_cnt++; if (tx_a[16] !== 1'b1 || busy_a[16] !== 1'b0 || done_a[16] !== 1'b0)
      $display("FAIL rmid_after: got tx=%b busy=%b done=%b want 1 0 0", tx_a[16], busy_a[16], done_a[16]); else pass_cnt++;
    check_cnt++; if (done_cnt(90) != 0) $display("FAIL rmid_no_done: got %0d want 0", done_cnt(90)); else pass_cnt++;
    check_cnt++; if (busy_cnt(90) != 15) $display("FAIL rmid_busy_len: got %0d want 15", busy_cnt(90)); else pass_cnt++;
    drive_send(8'h2A, 1'b0, 1'b0, 1'b0);
    capture(84, -1, 8'h00, -1);
    check_cnt++; if (dec(0) !== 8'h2A || frame_ok(0) !== 1'b1) $display("FAIL rmid_byte0: got %h want 2a", dec(0)); else pass_cnt++;
    check_cnt++; if (dec(1) !== 8'h00 || frame_ok(1) !== 1'b1) $display("FAIL rmid_byte1: got %h want 00", dec(1)); else pass_cnt++;
    check_cnt++; if (done_at(84) != 81) $display("FAIL rmid_done_at: got %0d want 81", done_at(84)); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_flags();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
